pipe_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS core. It combines the load-use hazard from the forwarding unit, the occupancy of the shared multi-cycle multiply/divide (HI/LO) unit and committed exceptions. From these it drives per-stage advance enables, bubble and flush strobes, and the start/abort handshake to the mul/div unit. It sits beside the forwarding unit, between the decode-stage hazard logic and the pipeline registers.

---
 rtl/pipe_ctrl_pkg.sv | 15 +
 rtl/pipe_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encoding
// and default mul/div latencies.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN     = 2'd0,
    PC_MD_BUSY = 2'd1,
    PC_FLUSH   = 2'd2
  } pc_state_e;

  localparam int MUL_CYCLES_DEF = 2;
  localparam int DIV_CYCLES_DEF = 33;
  localparam int CNT_W_DEF      = 6;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges load-use, HI/LO occupancy and
// committed exceptions into stage enables, bubble/flush strobes and mul/div handshake.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic load_use_hz,
  input  logic md_req,
  input  logic md_is_div,
  input  logic de_reads_hilo,
  input  logic exc_req,
  output logic fe_en,
  output logic de_en,
  output logic exe_bubble,
  output logic mem_en,
  output logic de_flush,
  output logic exe_flush,
  output logic mem_flush,
  output logic pc_redirect,
  output logic md_fire,
  output logic md_abort,
  output logic md_busy
);

  pc_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             hilo_hz, stall, issue;

  assign hilo_hz = (state == PC_MD_BUSY) && (de_reads_hilo || md_req);
  assign stall   = !exc_req && (state != PC_FLUSH) && (hilo_hz || load_use_hz);
  // a mul/div only leaves DE from RUN and only when DE is actually advancing
  assign issue   = !exc_req && (state == PC_RUN) && md_req && !load_use_hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PC_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (exc_req) begin
      state_nx = PC_FLUSH;
      cnt_nx   = '0;
    end else begin
      case (state)
        PC_RUN: begin
          if (issue) begin
            state_nx = PC_MD_BUSY;
            cnt_nx   = md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
          end
        end
        PC_MD_BUSY: begin
          cnt_nx = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_nx = PC_RUN;
        end
        PC_FLUSH: state_nx = PC_RUN;
        default: begin
          state_nx = PC_RUN;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // outputs stay low while rst is held, enables included
  always_comb begin
    fe_en       = 1'b0;
    de_en       = 1'b0;
    exe_bubble  = 1'b0;
    mem_en      = 1'b0;
    de_flush    = 1'b0;
    exe_flush   = 1'b0;
    mem_flush   = 1'b0;
    pc_redirect = 1'b0;
    md_fire     = 1'b0;
    md_abort    = 1'b0;
    if (!rst) begin
      if (exc_req) begin
        {fe_en, de_en, mem_en}                          = 3'b111;
        {de_flush, exe_flush, mem_flush, pc_redirect}   = 4'b1111;
        md_abort                                        = (state == PC_MD_BUSY);
      end else if (state == PC_FLUSH) begin
        {fe_en, de_en, mem_en} = 3'b111;
        de_flush               = 1'b1;
      end else if (stall) begin
        exe_bubble = 1'b1;
        mem_en     = 1'b1;
      end else begin
        {fe_en, de_en, mem_en} = 3'b111;
        md_fire                = issue;
      end
    end
  end

  assign md_busy = (state == PC_MD_BUSY);

endmodule
